mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between instruction fetch (IF) and the data load/store path.
- The data path feeds the writeback stage's load extension/merge logic.
- Sequences one memory transaction at a time with a fixed read latency. Generates per-requester stall and valid strobes, and discards fetch responses made stale by a redirect/flush.
- Data requests win by default; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the
// data load/store path, one fixed-latency transaction at a time.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] lat_cnt, lat_nx;
  logic [CW-1:0] starve_cnt, starve_nx;
  logic          discard, discard_nx;
  logic          d_we_q, d_we_nx;
  logic          ifr;

  assign ifr = if_req & ~if_flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      discard    <= 1'b0;
      d_we_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      lat_cnt    <= lat_nx;
      starve_cnt <= starve_nx;
      discard    <= discard_nx;
      d_we_q     <= d_we_nx;
    end
  end

  // Grant, sequencing and completion
  always_comb begin
    state_nx   = state;
    lat_nx     = lat_cnt;
    starve_nx  = starve_cnt;
    discard_nx = discard;
    d_we_nx    = d_we_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if_valid   = 1'b0;
    if_rdata   = 32'h0;
    d_valid    = 1'b0;
    d_rdata    = 32'h0;

    case (state)
      IDLE: begin
        discard_nx = 1'b0;
        if (d_req && (!ifr || starve_cnt != STARVE_TOP)) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_be    = d_we ? d_be : 4'hF;
          mem_addr  = d_addr;
          mem_wdata = d_we ? d_wdata : 32'h0;
          state_nx  = BUSY_D;
          lat_nx    = LAT_LOAD;
          d_we_nx   = d_we;
          if (if_req && starve_cnt != STARVE_TOP)
            starve_nx = starve_cnt + CW'(1);
        end else if (ifr) begin
          mem_en    = 1'b1;
          mem_be    = 4'hF;
          mem_addr  = if_addr;
          state_nx  = BUSY_IF;
          lat_nx    = LAT_LOAD;
          starve_nx = '0;
        end
      end
      BUSY_IF: begin
        if (if_flush) discard_nx = 1'b1;
        if (lat_cnt == '0) begin
          state_nx   = IDLE;
          discard_nx = 1'b0;
          if (!discard && !if_flush) begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
          end
        end else begin
          lat_nx = lat_cnt - CW'(1);
        end
      end
      BUSY_D: begin
        if (lat_cnt == '0) begin
          state_nx = IDLE;
          d_valid  = 1'b1;
          d_rdata  = d_we_q ? 32'h0 : mem_rdata;
        end else begin
          lat_nx = lat_cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Responses in flight across reset are ignored and the port is quiet
    if (rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if_valid  = 1'b0;
      if_rdata  = 32'h0;
      d_valid   = 1'b0;
      d_rdata   = 32'h0;
    end
  end

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory returns data exactly MEM_LAT cycles after mem_en, junk otherwise
  logic [MEM_LAT-1:0] vpipe = '0;
  logic [31:0]        apipe [MEM_LAT];
  always @(posedge clk) begin
    vpipe[0] <= mem_en;
    apipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      apipe[i] <= apipe[i-1];
    end
  end
  assign mem_rdata = vpipe[MEM_LAT-1] ? mem_word(apipe[MEM_LAT-1]) : 32'hBAD0_BAD0;

  // A waiting requester must keep its request up (fetch may drop under flush)
  logic prev_ds = 1'b0, prev_is = 1'b0;
  always @(negedge clk) begin
    if (!rst && prev_ds && !d_req) $error("protocol: d_req dropped while in flight");
    if (!rst && prev_is && !if_req && !if_flush) $error("protocol: if_req dropped while in flight");
    prev_ds = rst ? 1'b0 : d_stall;
    prev_is = rst ? 1'b0 : if_stall;
  end

  typedef struct {
    logic rst, ir; logic [31:0] ia; logic fl;
    logic dr, dwe; logic [3:0] dbe; logic [31:0] da, dwd;
    logic en, we; logic [3:0] be; logic [31:0] ma, mwd;
    logic iv; logic [31:0] ird; logic is;
    logic dv; logic [31:0] drd; logic ds;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   miscompares = 0;

  function automatic vec_t mk(
    logic r, logic ir, logic [31:0] ia, logic fl,
    logic dr, logic dwe, logic [3:0] dbe, logic [31:0] da, logic [31:0] dwd,
    logic en, logic we, logic [3:0] be, logic [31:0] ma, logic [31:0] mwd,
    logic iv, logic [31:0] ird, logic is, logic dv, logic [31:0] drd, logic ds);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.fl = fl;
    v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
    v.en = en; v.we = we; v.be = be; v.ma = ma; v.mwd = mwd;
    v.iv = iv; v.ird = ird; v.is = is; v.dv = dv; v.drd = drd; v.ds = ds;
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; if_req = v.ir; if_addr = v.ia; if_flush = v.fl;
    d_req = v.dr; d_we = v.dwe; d_be = v.dbe; d_addr = v.da; d_wdata = v.dwd;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    nvec++;
    chk(idx, "mem_en", 32'(mem_en), 32'(v.en));
    chk(idx, "mem_we", 32'(mem_we), 32'(v.we));
    chk(idx, "mem_be", 32'(mem_be), 32'(v.be));
    chk(idx, "mem_addr", mem_addr, v.ma);
    chk(idx, "mem_wdata", mem_wdata, v.mwd);
    chk(idx, "if_valid", 32'(if_valid), 32'(v.iv));
    chk(idx, "if_rdata", if_rdata, v.ird);
    chk(idx, "if_stall", 32'(if_stall), 32'(v.is));
    chk(idx, "d_valid", 32'(d_valid), 32'(v.dv));
    chk(idx, "d_rdata", d_rdata, v.drd);
    chk(idx, "d_stall", 32'(d_stall), 32'(v.ds));
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    // reset
    vecs.push_back(mk(1,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    vecs.push_back(mk(1,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // single fetch of 0x100
    vecs.push_back(mk(0,1,32'h100,0, 0,0,0,Z,Z,    1,0,4'hF,32'h100,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h100,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h100,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                1,32'hDEAD_BEEF,0, 0,Z,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // store with partial byte enables
    vecs.push_back(mk(0,0,Z,0, 1,1,4'h3,32'h2000,32'h1234, 1,1,4'h3,32'h2000,32'h1234, 0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,1,4'h3,32'h2000,32'h1234, 0,0,0,Z,Z,     0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,1,4'h3,32'h2000,32'h1234, 0,0,0,Z,Z,     0,Z,0, 1,Z,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // load
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h3000,Z, 1,0,4'hF,32'h3000,Z,     0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h3000,Z, 0,0,0,Z,Z,               0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h3000,Z, 0,0,0,Z,Z,               0,Z,0, 1,32'h5A5A_3000,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // flush mid-fetch, redirected fetch to 0x200
    vecs.push_back(mk(0,1,32'h100,0, 0,0,0,Z,Z,    1,0,4'hF,32'h100,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h200,1, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h200,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h200,0, 0,0,0,Z,Z,    1,0,4'hF,32'h200,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h200,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h200,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                1,32'h5A5A_0200,0, 0,Z,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // reset during a load, load regranted afterwards
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h4000,Z, 1,0,4'hF,32'h4000,Z,     0,Z,0, 0,Z,1));
    vecs.push_back(mk(1,0,Z,0, 1,0,4'hF,32'h4000,Z, 0,0,0,Z,Z,               0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h4000,Z, 1,0,4'hF,32'h4000,Z,     0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h4000,Z, 0,0,0,Z,Z,               0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h4000,Z, 0,0,0,Z,Z,               0,Z,0, 1,32'h5A5A_4000,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // flush in idle masks the fetch for that cycle
    vecs.push_back(mk(0,1,32'h300,1, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h300,0, 0,0,0,Z,Z,    1,0,4'hF,32'h300,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h300,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h300,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                1,32'h5A5A_0300,0, 0,Z,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // flush in the completion cycle suppresses if_valid
    vecs.push_back(mk(0,1,32'h500,0, 0,0,0,Z,Z,    1,0,4'hF,32'h500,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h500,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h500,1, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h500,0, 0,0,0,Z,Z,    1,0,4'hF,32'h500,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h500,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h500,0, 0,0,0,Z,Z,    0,0,0,Z,Z,                1,32'h5A5A_0500,0, 0,Z,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));
    // data request arriving during a fetch waits for idle
    vecs.push_back(mk(0,1,32'h600,0, 0,0,0,Z,Z,    1,0,4'hF,32'h600,Z,       0,Z,1, 0,Z,0));
    vecs.push_back(mk(0,1,32'h600,0, 1,0,4'hF,32'h700,Z, 0,0,0,Z,Z,          0,Z,1, 0,Z,1));
    vecs.push_back(mk(0,1,32'h600,0, 1,0,4'hF,32'h700,Z, 0,0,0,Z,Z,          1,32'h5A5A_0600,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h700,Z, 1,0,4'hF,32'h700,Z,       0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h700,Z, 0,0,0,Z,Z,                0,Z,0, 0,Z,1));
    vecs.push_back(mk(0,0,Z,0, 1,0,4'hF,32'h700,Z, 0,0,0,Z,Z,                0,Z,0, 1,32'h5A5A_0700,0));
    vecs.push_back(mk(0,0,Z,0, 0,0,0,Z,Z,          0,0,0,Z,Z,                0,Z,0, 0,Z,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Contention: data wins until the starvation limit, then fetch; twice over
    rst = 0; if_flush = 0;
    if_req = 1; if_addr = 32'h800;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h900; d_wdata = 32'h0;
    for (int c = 0; c < 30; c++) begin
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_iv;
      exp_en   = (c % 3 == 0);
      exp_addr = !exp_en ? 32'h0 : ((c == 12 || c == 27) ? 32'h800 : 32'h900);
      exp_iv   = (c == 14 || c == 29);
      @(negedge clk);
      nvec++;
      chk(100 + c, "contend mem_en", 32'(mem_en), 32'(exp_en));
      chk(100 + c, "contend mem_addr", mem_addr, exp_addr);
      chk(100 + c, "contend if_valid", 32'(if_valid), 32'(exp_iv));
      @(posedge clk);
      #1;
    end
    rst = 1; if_req = 0; d_req = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    nvec++;
    chk(200, "final reset mem_en", 32'(mem_en), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
